seq_div32: RTL
==============

Name: seq_div32

Overview:
- Iterative signed 32-bit divider. Inverse companion to the datapath's combinational multiplier.
- Produces quotient and remainder using one restoring shift-subtract step per clock.
- Valid/ready handshakes on both sides, so the execute stage can stall on it without combinational depth.
- Sits beside the multiplier in the ALU complex and serves DIV/REM instructions.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH; counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands presented
- in_ready  output  1  block idle, can accept operands
- dividend  input  WIDTH  signed dividend
- divisor  input  WIDTH  signed divisor
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder, sign follows dividend
- div_by_zero  output  1  flag, valid while out_valid

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high. rst forces state IDLE at any time, including mid-operation; the operation in flight is discarded.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture operands, signs and absolute values. Working remainder=0, count=0.
  - divisor==0 -> DONE with quotient=all-ones (-1), remainder=dividend, div_by_zero=1.
  - dividend==most-negative && divisor==-1 -> DONE with quotient=most-negative, remainder=0, div_by_zero=0.
  - Otherwise -> CALC.
- CALC, one step per cycle:
  - Shift {rem, quo_abs} left by 1.
  - trial = rem_shifted - divisor_abs, computed at WIDTH+1 bits.
  - If trial is non-negative: rem=trial, quotient LSB=1. Else quotient LSB=0.
  - count increments. After the WIDTH-th step (count reaches WIDTH-1 and steps), -> FIX.
- FIX, one cycle:
  - Negate the quotient if sign(dividend)^sign(divisor).
  - Negate the remainder if sign(dividend).
  - Load the output registers, -> DONE.
- DONE:
  - out_valid=1; outputs held stable.
  - out_ready=1 -> IDLE with out_valid=0 on the next edge.
  - in_ready=0 in DONE; a new op cannot be accepted until the cycle after the result is consumed.
- Latency:
  - Normal op: out_valid rises WIDTH+2 edges after the accepting edge (34 for WIDTH=32).
  - Special cases: out_valid rises 1 edge after the accepting edge.
- Boundaries and conventions:
  - Operands are registered at acceptance; input changes during CALC are ignored.
  - Zero dividend yields q=0, r=0 via the normal path.
  - |divisor| > |dividend| yields q=0, r=dividend.
  - Absolute value of most-negative is taken as unsigned WIDTH bits (no overflow).
  - out_valid never drops without out_ready, except on rst.
  - in_valid while busy is ignored (in_ready=0).

Optional Feature:
- Macro: SEQ_DIV_UNSIGNED_EN.
- Defined:
  - Adds input port op_unsigned (1 bit), sampled at acceptance.
  - When op_unsigned=1, operands are unsigned, no sign fixup occurs, and the overflow special case is disabled.
  - Divide-by-zero still gives quotient=all-ones, remainder=dividend.
- Undefined: port absent; all operations are signed.

Test Plan:
- Reset mid-op: accept 100/7, assert rst at cycle 10 -> out_valid=0, in_ready=1 immediately. A following 100/7 -> q=14, r=2.
- Basic: dividend=100, divisor=7 -> after 34 cycles out_valid=1, q=14, r=2, div_by_zero=0. Result held for 5 cycles with out_ready=0, then consumed -> in_ready=1 next cycle.
- Signs: -7/2 -> q=-3 (0xFFFFFFFD), r=-1. 7/-2 -> q=-3, r=1. -7/-2 -> q=3, r=-1.
- Specials:
  - 7/0 -> out_valid 1 cycle after accept, q=0xFFFFFFFF, r=7, div_by_zero=1.
  - 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, 1-cycle latency.
- Back-to-back: in_valid held high with fresh operands, out_ready tied 1 -> ops 1000/10 (q=100, r=0) and 0x7FFFFFFF/1 (q=0x7FFFFFFF, r=0) complete in order. in_ready=0 throughout each op.
- With SEQ_DIV_UNSIGNED_EN, op_unsigned=1: 0xFFFFFFFF/2 -> q=0x7FFFFFFF, r=1. Same operands with op_unsigned=0 -> q=0, r=-1.

Source files
------------

// File: rtl/seq_div32.sv
`default_nettype none
// ============================================================================
// Module   : seq_div32
// Purpose  : Iterative signed divider. One restoring shift-subtract step per
//            clock, with valid/ready handshakes on both sides. Divide-by-zero
//            and most-negative / -1 overflow are answered without iterating.
// Options  : SEQ_DIV_UNSIGNED_EN adds an op_unsigned input that selects
//            unsigned operands for the operation being accepted.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`ifdef SEQ_DIV_UNSIGNED_EN
  ,
  input  logic             op_unsigned
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs_abs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CW-1:0]    r_count;

  logic             w_uns;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_ovf;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

`ifdef SEQ_DIV_UNSIGNED_EN
  assign w_uns = op_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  // Operand signs and magnitudes; |most-negative| stays correct as unsigned.
  assign w_dvd_neg = ~w_uns & dividend[WIDTH-1];
  assign w_dvs_neg = ~w_uns & divisor[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_abs = w_dvs_neg ? (~divisor + 1'b1) : divisor;

  // Signed overflow: most-negative divided by -1.
  assign w_ovf = ~w_uns && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (divisor == {WIDTH{1'b1}});

  // One restoring step: the extra MSB keeps the trial sign unambiguous.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs_abs};

  // Sign fixup of the magnitude results.
  assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  // Control FSM and datapath registers, including all output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs_abs   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_count     <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            r_rem     <= '0;
            r_count   <= '0;
            r_quo     <= w_dvd_abs;
            r_dvs_abs <= w_dvs_abs;
            r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r   <= w_dvd_neg;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_ovf) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (w_trial[WIDTH]) begin
            r_rem <= w_rem_sh[WIDTH-1:0];
          end else begin
            r_rem <= w_trial[WIDTH-1:0];
          end
          r_quo   <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          quotient    <= w_q_fix;
          remainder   <= w_r_fix;
          div_by_zero <= 1'b0;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          // First DONE cycle raises out_valid; afterwards wait for the consumer.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
